// File: rtl/swt16_hazard_ctrl_if.sv
// Decoder <-> hazard controller bundle: DC operand/destination info in, stall/flush/forward controls out.
// in_dc_valid qualifies every in_dc_* field for the current cycle; outputs are valid every cycle (no ready).
interface swt16_hazard_ctrl_if #(
    parameter int REG_IDX_WIDTH = 4
);
    logic                     in_dc_valid;
    logic [REG_IDX_WIDTH-1:0] in_dc_src1_idx;
    logic                     in_dc_src1_used;
    logic [REG_IDX_WIDTH-1:0] in_dc_src2_idx;
    logic                     in_dc_src2_used;
    logic [REG_IDX_WIDTH-1:0] in_dc_dst_idx;
    logic                     in_dc_wr_reg;
    logic                     in_dc_is_load;
    logic                     in_set_pc;
    logic                     out_stall;
    logic                     out_bubble;
    logic                     out_flush;
    logic [2:0]               out_fwd_sel1;
    logic [2:0]               out_fwd_sel2;

    modport master (
        output in_dc_valid, in_dc_src1_idx, in_dc_src1_used, in_dc_src2_idx, in_dc_src2_used,
               in_dc_dst_idx, in_dc_wr_reg, in_dc_is_load, in_set_pc,
        input  out_stall, out_bubble, out_flush, out_fwd_sel1, out_fwd_sel2
    );

    modport slave (
        input  in_dc_valid, in_dc_src1_idx, in_dc_src1_used, in_dc_src2_idx, in_dc_src2_used,
               in_dc_dst_idx, in_dc_wr_reg, in_dc_is_load, in_set_pc,
        output out_stall, out_bubble, out_flush, out_fwd_sel1, out_fwd_sel2
    );
endinterface

// File: rtl/swt16_hazard_ctrl.sv
// swt16 hazard controller: scoreboard of in-flight destinations driving forwarding selects,
// load-use stalls and multi-cycle flushes after taken jumps.
module swt16_hazard_ctrl #(
    parameter int REG_IDX_WIDTH    = 4,
    parameter int NUM_TRACK_STAGES = 3,
    parameter int LOAD_USE_STALL   = 1,
    parameter int FLUSH_CYCLES     = 2,
    parameter bit ZERO_REG_FIXED   = 1'b1
) (
    input  logic               clock,
    input  logic               reset,
    swt16_hazard_ctrl_if.slave hz
);
    localparam int N    = NUM_TRACK_STAGES;
    localparam int W    = REG_IDX_WIDTH;
    localparam int SC_W = (LOAD_USE_STALL > 0) ? $clog2(LOAD_USE_STALL + 1) : 1;
    localparam int FC_W = $clog2(FLUSH_CYCLES + 1);
    // The detection cycle itself is the first stall/flush cycle, so counters load max-1.
    localparam logic [SC_W-1:0] STALL_RELOAD = SC_W'((LOAD_USE_STALL > 0) ? LOAD_USE_STALL - 1 : 0);
    localparam logic [FC_W-1:0] FLUSH_RELOAD = FC_W'(FLUSH_CYCLES - 1);

    logic [N-1:0]        sb_vld_q, sb_vld_d;
    logic [N-1:0]        sb_wr_q, sb_wr_d;
    logic [N-1:0]        sb_ld_q, sb_ld_d;
    logic [N-1:0][W-1:0] sb_dst_q, sb_dst_d;
    logic [SC_W-1:0]     stall_cnt_q, stall_cnt_d;
    logic [FC_W-1:0]     flush_cnt_q, flush_cnt_d;

    logic [N-1:0] match1, match2;
    logic [2:0]   sel1, sel2;
    logic         flush_req, flush, ld_hit, stall;

    always_comb begin
        match1 = '0;
        match2 = '0;
        for (int k = 0; k < N; k++) begin
            match1[k] = hz.in_dc_src1_used & sb_vld_q[k] & sb_wr_q[k]
                      & (sb_dst_q[k] == hz.in_dc_src1_idx)
                      & !(ZERO_REG_FIXED && (hz.in_dc_src1_idx == '0));
            match2[k] = hz.in_dc_src2_used & sb_vld_q[k] & sb_wr_q[k]
                      & (sb_dst_q[k] == hz.in_dc_src2_idx)
                      & !(ZERO_REG_FIXED && (hz.in_dc_src2_idx == '0));
        end
    end

    // Scan oldest to youngest so the youngest match overwrites older ones.
    always_comb begin
        sel1 = '0;
        sel2 = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (match1[k]) sel1 = 3'(k + 1);
            if (match2[k]) sel2 = 3'(k + 1);
        end
    end

    // in_set_pc is masked in reset so outputs stay low while reset is held.
    assign flush_req = hz.in_set_pc & reset;
    assign flush     = flush_req | (flush_cnt_q != '0);
    assign ld_hit    = (LOAD_USE_STALL != 0) && hz.in_dc_valid && sb_ld_q[0]
                     && (match1[0] || match2[0]);
    assign stall     = !flush && (ld_hit || (stall_cnt_q != '0));

    always_comb begin
        stall_cnt_d = '0;
        if (flush)                   stall_cnt_d = '0;
        else if (stall_cnt_q != '0)  stall_cnt_d = stall_cnt_q - 1'b1;
        else if (ld_hit)             stall_cnt_d = STALL_RELOAD;

        flush_cnt_d = '0;
        if (flush_req)               flush_cnt_d = FLUSH_RELOAD;
        else if (flush_cnt_q != '0)  flush_cnt_d = flush_cnt_q - 1'b1;
    end

    always_comb begin
        sb_vld_d    = '0;
        sb_wr_d     = '0;
        sb_ld_d     = '0;
        sb_dst_d    = '0;
        sb_vld_d[0] = hz.in_dc_valid & !stall & !flush;
        sb_wr_d[0]  = hz.in_dc_wr_reg;
        sb_ld_d[0]  = hz.in_dc_is_load;
        sb_dst_d[0] = hz.in_dc_dst_idx;
        for (int k = 1; k < N; k++) begin
            sb_vld_d[k] = sb_vld_q[k-1];
            sb_wr_d[k]  = sb_wr_q[k-1];
            sb_ld_d[k]  = sb_ld_q[k-1];
            sb_dst_d[k] = sb_dst_q[k-1];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sb_vld_q    <= '0;
            sb_wr_q     <= '0;
            sb_ld_q     <= '0;
            sb_dst_q    <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            sb_vld_q    <= sb_vld_d;
            sb_wr_q     <= sb_wr_d;
            sb_ld_q     <= sb_ld_d;
            sb_dst_q    <= sb_dst_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign hz.out_stall    = stall;
    assign hz.out_bubble   = stall | flush;
    assign hz.out_flush    = flush;
    assign hz.out_fwd_sel1 = sel1;
    assign hz.out_fwd_sel2 = sel2;
endmodule

// File: tb/tb_swt16_hazard_ctrl.sv
// Directed bench for swt16_hazard_ctrl with default parameters (3 stages, 1 stall cycle, 2 flush cycles).
module tb_swt16_hazard_ctrl;
    logic clock;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    swt16_hazard_ctrl_if #(.REG_IDX_WIDTH(4)) ifc ();

    swt16_hazard_ctrl #(
        .REG_IDX_WIDTH(4), .NUM_TRACK_STAGES(3), .LOAD_USE_STALL(1),
        .FLUSH_CYCLES(2), .ZERO_REG_FIXED(1'b1)
    ) dut (
        .clock(clock),
        .reset(reset),
        .hz   (ifc.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Observed vector layout: {stall, bubble, flush, fwd_sel1[2:0], fwd_sel2[2:0]}
    function automatic logic [8:0] obs();
        return {ifc.out_stall, ifc.out_bubble, ifc.out_flush, ifc.out_fwd_sel1, ifc.out_fwd_sel2};
    endfunction

    function automatic logic [8:0] ev(input logic s, input logic b, input logic f,
                                      input logic [2:0] s1, input logic [2:0] s2);
        return {s, b, f, s1, s2};
    endfunction

    // Apply one DC slot at the falling edge and settle before sampling.
    task automatic drive(input logic v, input logic [3:0] s1, input logic u1,
                         input logic [3:0] s2, input logic u2, input logic [3:0] d,
                         input logic wr, input logic ld, input logic pc);
        @(negedge clock);
        ifc.in_dc_valid     = v;
        ifc.in_dc_src1_idx  = s1;
        ifc.in_dc_src1_used = u1;
        ifc.in_dc_src2_idx  = s2;
        ifc.in_dc_src2_used = u2;
        ifc.in_dc_dst_idx   = d;
        ifc.in_dc_wr_reg    = wr;
        ifc.in_dc_is_load   = ld;
        ifc.in_set_pc       = pc;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        logic [8:0] e;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'(($urandom_range(0, 1))), 4'($urandom_range(0, 15)), 1'b1,
                  4'($urandom_range(0, 15)), 1'b1, 4'($urandom_range(0, 15)),
                  1'b1, 1'($urandom_range(0, 1)), 1'b1);
            e = ev(0, 0, 0, 0, 0);
            if (obs() !== e) begin n_fail++; $display("FAIL reset_hold[%0d]: got %b exp %b", i, obs(), e); end
            n_checks++;
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        #1;
        e = ev(0, 0, 0, 0, 0);
        if (obs() !== e) begin n_fail++; $display("FAIL reset_release: got %b exp %b", obs(), e); end
        n_checks++;
        drive(1, 4'd5, 1, 4'd6, 1, 4'd7, 1, 0, 0);
        if (obs() !== e) begin n_fail++; $display("FAIL reset_first_slot: got %b exp %b", obs(), e); end
        n_checks++;
    endtask

    task automatic test_back_to_back();
        logic [8:0] e;
        idle(3);
        drive(1, 4'd1, 1, 4'd2, 1, 4'd3, 1, 0, 0);   // add r3,r1,r2
        e = ev(0, 0, 0, 0, 0);
        if (obs() !== e) begin n_fail++; $display("FAIL b2b_first: got %b exp %b", obs(), e); end
        n_checks++;
        drive(1, 4'd3, 1, 4'd1, 1, 4'd4, 1, 0, 0);   // add r4,r3,r1
        e = ev(0, 0, 0, 3'd1, 3'd0);
        if (obs() !== e) begin n_fail++; $display("FAIL b2b_dep: got %b exp %b", obs(), e); end
        n_checks++;
        drive(1, 4'd4, 1, 4'd3, 1, 4'd5, 1, 0, 0);   // add r5,r4,r3
        e = ev(0, 0, 0, 3'd1, 3'd2);
        if (obs() !== e) begin n_fail++; $display("FAIL b2b_two_deps: got %b exp %b", obs(), e); end
        n_checks++;
    endtask

    task automatic test_load_use();
        logic [8:0] e;
        idle(3);
        drive(1, 4'd1, 1, 4'd0, 0, 4'd5, 1, 1, 0);   // load r5
        e = ev(0, 0, 0, 0, 0);
        if (obs() !== e) begin n_fail++; $display("FAIL lu_load: got %b exp %b", obs(), e); end
        n_checks++;
        drive(1, 4'd5, 1, 4'd6, 1, 4'd7, 1, 0, 0);   // add r7,r5,r6
        e = ev(1, 1, 0, 3'd1, 3'd0);
        if (obs() !== e) begin n_fail++; $display("FAIL lu_stall: got %b exp %b", obs(), e); end
        n_checks++;
        drive(1, 4'd5, 1, 4'd6, 1, 4'd7, 1, 0, 0);   // same slot, held by stall
        e = ev(0, 0, 0, 3'd2, 3'd0);
        if (obs() !== e) begin n_fail++; $display("FAIL lu_release: got %b exp %b", obs(), e); end
        n_checks++;
        drive(1, 4'd5, 1, 4'd7, 1, 4'd8, 1, 0, 0);
        e = ev(0, 0, 0, 3'd3, 3'd1);
        if (obs() !== e) begin n_fail++; $display("FAIL lu_after: got %b exp %b", obs(), e); end
        n_checks++;
        idle(3);
        drive(1, 4'd1, 1, 4'd0, 0, 4'd5, 1, 1, 0);   // load r5
        drive(0, 4'd5, 1, 4'd0, 0, 4'd9, 1, 0, 0);   // invalid slot reading r5
        e = ev(0, 0, 0, 3'd1, 3'd0);
        if (obs() !== e) begin n_fail++; $display("FAIL lu_invalid_slot: got %b exp %b", obs(), e); end
        n_checks++;
    endtask

    task automatic test_zero_reg();
        logic [8:0] e;
        idle(3);
        drive(1, 4'd1, 1, 4'd2, 1, 4'd0, 1, 0, 0);   // write r0
        drive(1, 4'd0, 1, 4'd0, 1, 4'd3, 1, 0, 0);   // read r0,r0
        e = ev(0, 0, 0, 0, 0);
        if (obs() !== e) begin n_fail++; $display("FAIL zero_alu: got %b exp %b", obs(), e); end
        n_checks++;
        idle(3);
        drive(1, 4'd1, 1, 4'd0, 0, 4'd0, 1, 1, 0);   // load r0
        drive(1, 4'd0, 1, 4'd0, 1, 4'd3, 1, 0, 0);
        if (obs() !== e) begin n_fail++; $display("FAIL zero_load: got %b exp %b", obs(), e); end
        n_checks++;
    endtask

    task automatic test_youngest_wins();
        logic [8:0] e;
        idle(3);
        drive(1, 4'd1, 1, 4'd2, 1, 4'd7, 1, 0, 0);   // write r7
        drive(1, 4'd1, 1, 4'd2, 1, 4'd7, 1, 0, 0);   // write r7 again
        drive(1, 4'd7, 1, 4'd0, 0, 4'd8, 1, 0, 0);
        e = ev(0, 0, 0, 3'd1, 3'd0);
        if (obs() !== e) begin n_fail++; $display("FAIL young_e0: got %b exp %b", obs(), e); end
        n_checks++;
        drive(1, 4'd7, 1, 4'd0, 0, 4'd8, 1, 0, 0);
        e = ev(0, 0, 0, 3'd2, 3'd0);
        if (obs() !== e) begin n_fail++; $display("FAIL young_e1: got %b exp %b", obs(), e); end
        n_checks++;
        drive(1, 4'd7, 0, 4'd7, 1, 4'd9, 1, 0, 0);   // src1 unused
        e = ev(0, 0, 0, 3'd0, 3'd3);
        if (obs() !== e) begin n_fail++; $display("FAIL young_unused: got %b exp %b", obs(), e); end
        n_checks++;
    endtask

    task automatic test_jump();
        logic [8:0] e;
        idle(3);
        drive(1, 4'd1, 1, 4'd2, 1, 4'd9, 1, 0, 0);   // add r9
        drive(1, 4'd9, 1, 4'd0, 0, 4'd10, 1, 0, 1);  // jump taken, slot reads r9
        e = ev(0, 1, 1, 3'd1, 3'd0);
        if (obs() !== e) begin n_fail++; $display("FAIL jmp_c0: got %b exp %b", obs(), e); end
        n_checks++;
        drive(1, 4'd10, 1, 4'd9, 1, 4'd11, 1, 0, 0);
        e = ev(0, 1, 1, 3'd0, 3'd2);
        if (obs() !== e) begin n_fail++; $display("FAIL jmp_c1: got %b exp %b", obs(), e); end
        n_checks++;
        drive(1, 4'd10, 1, 4'd9, 1, 4'd11, 1, 0, 0);
        e = ev(0, 0, 0, 3'd0, 3'd3);
        if (obs() !== e) begin n_fail++; $display("FAIL jmp_end: got %b exp %b", obs(), e); end
        n_checks++;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        e = ev(0, 1, 1, 0, 0);
        if (obs() !== e) begin n_fail++; $display("FAIL jmp2_c0: got %b exp %b", obs(), e); end
        n_checks++;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);            // second pulse restarts the count
        if (obs() !== e) begin n_fail++; $display("FAIL jmp2_c1: got %b exp %b", obs(), e); end
        n_checks++;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        if (obs() !== e) begin n_fail++; $display("FAIL jmp2_c2: got %b exp %b", obs(), e); end
        n_checks++;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        e = ev(0, 0, 0, 0, 0);
        if (obs() !== e) begin n_fail++; $display("FAIL jmp2_end: got %b exp %b", obs(), e); end
        n_checks++;
    endtask

    task automatic test_stall_jump();
        logic [8:0] e;
        idle(3);
        drive(1, 4'd1, 1, 4'd0, 0, 4'd5, 1, 1, 0);   // load r5
        drive(1, 4'd5, 1, 4'd0, 0, 4'd6, 1, 0, 1);   // use r5 + jump
        e = ev(0, 1, 1, 3'd1, 3'd0);
        if (obs() !== e) begin n_fail++; $display("FAIL sj_c0: got %b exp %b", obs(), e); end
        n_checks++;
        drive(1, 4'd5, 1, 4'd0, 0, 4'd6, 1, 0, 0);
        e = ev(0, 1, 1, 3'd2, 3'd0);
        if (obs() !== e) begin n_fail++; $display("FAIL sj_c1: got %b exp %b", obs(), e); end
        n_checks++;
        drive(1, 4'd5, 1, 4'd0, 0, 4'd6, 1, 0, 0);
        e = ev(0, 0, 0, 3'd3, 3'd0);
        if (obs() !== e) begin n_fail++; $display("FAIL sj_after: got %b exp %b", obs(), e); end
        n_checks++;
    endtask

    task automatic test_reset_mid();
        logic [8:0] e;
        idle(3);
        drive(1, 4'd1, 1, 4'd0, 0, 4'd5, 1, 1, 0);   // load r5
        drive(1, 4'd5, 1, 4'd0, 0, 4'd6, 1, 0, 1);   // use r5 + jump
        e = ev(0, 1, 1, 3'd1, 3'd0);
        if (obs() !== e) begin n_fail++; $display("FAIL rm_pre: got %b exp %b", obs(), e); end
        n_checks++;
        reset = 1'b0;
        #1;
        e = ev(0, 0, 0, 0, 0);
        if (obs() !== e) begin n_fail++; $display("FAIL rm_async: got %b exp %b", obs(), e); end
        n_checks++;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        drive(1, 4'd5, 1, 4'd0, 0, 4'd6, 1, 0, 0);
        if (obs() !== e) begin n_fail++; $display("FAIL rm_clean: got %b exp %b", obs(), e); end
        n_checks++;
    endtask

    initial begin
        reset = 1'b0;
        ifc.in_dc_valid = 0; ifc.in_dc_src1_idx = 0; ifc.in_dc_src1_used = 0;
        ifc.in_dc_src2_idx = 0; ifc.in_dc_src2_used = 0; ifc.in_dc_dst_idx = 0;
        ifc.in_dc_wr_reg = 0; ifc.in_dc_is_load = 0; ifc.in_set_pc = 0;
        test_reset();
        test_back_to_back();
        test_load_use();
        test_zero_reg();
        test_youngest_wins();
        test_jump();
        test_stall_jump();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
